// File: rtl/mem_port_pkg.sv
// Shared types and constants for the multicycle processor memory port.
// State/op encodings and the legal access-latency range.
package mem_port_pkg;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with registered read (read-before-write).
// Contents are intentionally not reset.
module sync_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/multicycle_mem_port.sv
// Memory responder for the multicycle control FSM: accepts one read/write
// strobe in IDLE, waits LATENCY cycles, then pulses ready for one cycle.
module multicycle_mem_port
    import mem_port_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state;
    state_t            state_next;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;

    logic              req_one;
    logic              req_both;
    logic              accept;
    logic              last_beat;
    logic              read_done;
    logic              err_next;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign req_one  = mem_read ^ mem_write;
    assign req_both = mem_read & mem_write;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_one) state_next = ACCESS;
            ACCESS:  if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM address follows the live bus in IDLE so the registered read is
    // already pointing at the accepted address by the first ACCESS cycle.
    always_comb begin
        accept    = 1'b0;
        last_beat = 1'b0;
        read_done = 1'b0;
        err_next  = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        if (state == IDLE) begin
            accept   = req_one;
            err_next = req_both;
            ram_addr = addr;
        end
        if (state == ACCESS && cnt == '0) begin
            last_beat = 1'b1;
        end
        ram_we    = last_beat && (op_q == OP_WRITE) && !reset;
        read_done = last_beat && (op_q == OP_READ);
    end

    // Request latch, latency counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= mem_write ? OP_WRITE : OP_READ;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt     <= CNT_LOAD;
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (read_done) begin
                rdata <= ram_rdata;
            end
            ready <= (state_next == DONE);
            busy  <= (state_next != IDLE);
            err   <= err_next;
        end
    end

    sync_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/multicycle_mem_port.md
# multicycle_mem_port

Memory responder for the multicycle processor. Services the control FSM's `mem_read`/`mem_write` strobes against a word-addressed on-chip RAM with a fixed, parameterised access latency. Returns a one-cycle `ready` pulse and a registered read-data word that acts as the instruction/data register source. Sits between the control path (initiator) and the datapath address/write-data buses.

## Interface
- `DATA_W`, default 16: word width; one instruction is one word.
- `ADDR_W`, default 8: word address width; depth is 2^ADDR_W.
- `LATENCY`, default 2: access cycles, legal range 1..15.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `mem_read`  in  1  read request strobe (level).
- `mem_write`  in  1  write request strobe (level).
- `addr`  in  ADDR_W  word address, already muxed PC/ALU by the datapath.
- `wdata`  in  DATA_W  store data.
- `rdata`  out  DATA_W  registered read data; holds its value until the next completed read.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a request is in flight (ACCESS or DONE).
- `err`  out  1  one-cycle pulse on an illegal request.

## Operation
- Reset values: `rdata`=0, `ready`=0, `busy`=0, `err`=0, state IDLE, counter 0. RAM contents are not reset.
- States:
  - IDLE:
    - exactly one strobe high → latch `addr`, `wdata`, and op (read/write); load counter with LATENCY-1; go to ACCESS.
    - both strobes high → `err` pulses next cycle; nothing latched; stay IDLE.
    - no strobe → stay IDLE.
  - ACCESS:
    - counter≠0 → decrement.
    - counter==0 → go to DONE. On that edge, a read loads `rdata` from RAM[latched addr]; a write stores latched wdata into RAM[latched addr].
  - DONE: `ready`=1 for this cycle only; go to IDLE unconditionally.
- Strobes, `addr` and `wdata` are ignored outside IDLE; only the values latched at acceptance are used.
- Handshake contract: the initiator holds its strobe until it sees `ready`, then advances. A strobe seen in IDLE after DONE is a new request, so back-to-back accesses are legal.
- Reset mid-operation aborts the access: state returns to IDLE and no `ready` is produced. A write whose DONE edge has not yet occurred does not modify RAM. `rdata` returns to 0.
- Address wrap: none needed. `addr` spans the full depth; no out-of-range case exists.
- `busy` = (state≠IDLE), registered.

## Timing
- Strobe sampled high at edge k → `ready` high during cycle k+LATENCY+1.
- On a read, `rdata` is valid in the same cycle as `ready` and stays stable afterwards.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- `err` is high during cycle k+1 only.
- Read-after-write to the same address, issued as the next request, returns the new data: the write commits before DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `mem_port_pkg`:
  - state enum {IDLE, ACCESS, DONE};
  - op enum {OP_READ, OP_WRITE};
  - the LATENCY legal-range constants.
- Sub-module `sync_ram`: single-port synchronous RAM with ports `clk`, `we`, `addr`, `wdata`, `rdata`, and registered read. `multicycle_mem_port` drives it only on the ACCESS→DONE edge.
- Counter width is 4 bits, sized for the LATENCY maximum of 15.

## Test plan
- Reset then idle: hold strobes low for 10 cycles → `ready`, `busy`, `err` stay 0 and `rdata`=0x0000.
- Write then read, LATENCY=2:
  - write 0xBEEF to addr 0x12 at edge 0 → `ready` in cycle 3;
  - read 0x12 next → `ready` 4 cycles later with `rdata`=0xBEEF.
- Input change during ACCESS: after a read of 0x05 is accepted, change `addr` to 0x06 → data returned is RAM[0x05].
- Both strobes high in IDLE → `err`=1 for exactly one cycle, no `ready`, RAM[addr] unchanged.
- Reset mid-write: accept a write of 0x1234 to 0x20 (old value 0xAAAA), assert `reset` in the ACCESS cycle → no `ready` and a later read of 0x20 returns 0xAAAA.
- LATENCY=1 back-to-back reads of 0x00 and 0xFF (strobe re-asserted in the cycle after `ready`) → `ready` pulses 3 cycles apart, each with the correct `rdata`.
